i2c_mst: RTL and testbench
==========================

Name: i2c_mst

Overview:
- Byte-level I2C bus initiator (master). It drives SCL/SDA open-drain style to generate START, byte write, byte read and STOP sequences.
- It is the active counterpart of the team's passive I2C edge-count analyzer. That analyzer is wired to the same GPIO pins to observe this block's traffic.
- Single master only: no arbitration. Slave clock stretching is supported.

Parameters:
- CLK_DIV, 125, clk cycles per quarter SCL period (50 MHz / (4*125) = 100 kHz SCL); legal range 2..65535.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when a command can be accepted
- cmd  in  2  00 START, 01 WRITE, 10 READ, 11 STOP
- wdata  in  8  byte for WRITE, sampled on acceptance
- cmd_ack  in  1  READ only: 1 = master sends ACK (SDA low) in the 9th bit, 0 = NACK; sampled on acceptance
- done  out  1  one-cycle pulse when a command completes
- rdata  out  8  byte received by the last READ; valid from done onward
- ack_err  out  1  WRITE result: 1 = slave NACKed; updated with done
- busy  out  1  high from acceptance until done
- scl_i, sda_i  in  1 each  bus line levels (from pad)
- scl_oe, sda_oe  out  1 each  1 = pull line low, 0 = release (pad tri-state)

Behaviour:
- Reset (async, rst_n=0):
  - scl_oe=0, sda_oe=0, cmd_ready=1, busy=0, done=0, rdata=0x00, ack_err=0.
  - FSM goes to IDLE; the divider counter clears.
- Handshake:
  - A command is accepted on a rising clk edge with cmd_valid && cmd_ready.
  - cmd_ready is 1 only in IDLE. In the acceptance cycle cmd_ready drops and busy rises.
- Tick generation:
  - The divider counter clears on acceptance and counts 0..CLK_DIV-1.
  - A tick occurs when the count reaches CLK_DIV-1.
  - Each bit slot has phases P0..P3; a tick advances the phase.
- Clock stretching:
  - In any phase where scl_oe=0 is intended and scl_i=0 (slave holding SCL), the divider is held at 0 until scl_i=1.
  - Stretching may last indefinitely; there is no timeout.
- Phase actions (state entered at the start of the phase):
  - START: P0 sda_oe=0; P1 scl_oe=0; P2 sda_oe=1; P3 scl_oe=1. Identical for a first START and a repeated START.
  - WRITE: 9 slots. Slots 0..7 carry wdata MSB first; slot 8 is the ACK slot.
    - P0: scl_oe=1 and sda_oe=~bit. In the ACK slot sda_oe=0.
    - P1: hold.
    - P2: scl_oe=0 (stretch applies).
    - P3: hold.
    - sda_i is sampled at the P2->P3 tick.
    - At the end of the ACK slot, ack_err = sampled sda_i.
  - READ: 9 slots.
    - Slots 0..7: sda_oe=0, SCL sequenced as in WRITE. sda_i is shifted into rdata MSB first at each P2->P3 tick.
    - Slot 8: sda_oe=cmd_ack.
    - After slot 8, sda_oe=0.
  - STOP: P0 sda_oe=1 (scl still low); P1 scl_oe=0 (stretch); P2 sda_oe=0; P3 hold.
- Completion:
  - A command completes on the tick ending its last P3.
  - On the next clk edge: done=1 for one cycle, busy=0, cmd_ready=1, FSM back to IDLE.
- Idle line state:
  - After START, WRITE and READ, SCL remains held low (scl_oe=1) in IDLE.
  - After STOP and after reset, both lines are released.
- Latency without stretching:
  - START and STOP complete in 4*CLK_DIV cycles.
  - WRITE and READ complete in 36*CLK_DIV cycles.
  - Each is measured from the acceptance edge to the done pulse.
- Command sequencing:
  - WRITE, READ or STOP issued without a preceding START is executed as specified, with no error flag.
- Other registers:
  - rdata changes only during a READ.
  - ack_err changes only at WRITE completion.
- cmd_valid held high through a busy period is ignored until cmd_ready is 1.
- Reset mid-operation:
  - All outputs go to reset values immediately (asynchronous), so both lines are released.
  - No STOP is generated.

Test Plan (CLK_DIV=4, slave BFM on open-drain bus with pull-ups):
- Reset: assert rst_n=0 mid-run -> scl_oe=sda_oe=0, cmd_ready=1, busy=0, rdata=0x00 in the same cycle.
- START, WRITE 0xA5, slave ACKs, then STOP:
  - BFM captures 0xA5 and a START/STOP pair.
  - WRITE done arrives exactly 144 cycles after acceptance with ack_err=0.
  - Analyzer-style count on SCL gives 9 rising edges for the WRITE.
- WRITE 0x3C with no slave present (SDA floats high) -> ack_err=1 at done.
- READ, slave drives 0x5A:
  - cmd_ack=1 -> rdata=0x5A, SDA low during the 9th SCL high.
  - Repeat with cmd_ack=0 -> SDA high during the 9th bit.
- Clock stretch: slave holds SCL low for 50 cycles at bit 3 of a WRITE -> done is delayed by exactly 50 cycles versus the unstretched case, and data is still correct.
- Repeated START (START, WRITE, START, READ, STOP):
  - SDA falls while SCL is high at both STARTs.
  - cmd_valid held high during busy is accepted only when cmd_ready=1.

Source files
------------

// File: rtl/i2c_mst.sv
// Byte-level I2C bus master: START, WRITE, READ and STOP sequences on open-drain SCL/SDA.
// Each bit slot is four divider phases; a slave holding SCL low freezes the divider.
module i2c_mst #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
  input  logic       cmd_ack,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ack_err,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam logic [15:0] DivLast = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StStart, StWrite, StRead, StStop} state_e;

  state_e      state;
  logic [15:0] cnt;
  logic [1:0]  phase;
  logic [3:0]  slot;
  logic [7:0]  txd;
  logic        ack_bit;
  logic        rx_bit;
  logic        stretch;
  logic        tick;
  logic        last;

  // SCL released by us but still low: the slave is stretching the clock.
  assign stretch = ~scl_oe & ~scl_i;
  assign tick    = ~stretch & (cnt == DivLast);
  assign last    = (phase == 2'd3) &&
                   ((state == StStart) || (state == StStop) || (slot == 4'd8));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cnt       <= '0;
      phase     <= '0;
      slot      <= '0;
      txd       <= '0;
      ack_bit   <= 1'b0;
      rx_bit    <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      ack_err   <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == StIdle) begin
        if (cmd_valid) begin
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          cnt       <= '0;
          phase     <= '0;
          slot      <= '0;
          unique case (cmd)
            2'b00: begin
              state  <= StStart;
              sda_oe <= 1'b0;
            end
            2'b01: begin
              state  <= StWrite;
              txd    <= wdata;
              scl_oe <= 1'b1;
              sda_oe <= ~wdata[7];
            end
            2'b10: begin
              state   <= StRead;
              ack_bit <= cmd_ack;
              scl_oe  <= 1'b1;
              sda_oe  <= 1'b0;
            end
            2'b11: begin
              state  <= StStop;
              scl_oe <= 1'b1;
              sda_oe <= 1'b1;
            end
          endcase
        end
      end else if (stretch) begin
        cnt <= '0;
      end else if (!tick) begin
        cnt <= cnt + 16'd1;
      end else begin
        cnt   <= '0;
        phase <= phase + 2'd1;
        unique case (state)
          StStart: begin
            unique case (phase)
              2'd0:    scl_oe <= 1'b0;
              2'd1:    sda_oe <= 1'b1;
              2'd2:    scl_oe <= 1'b1;
              default: ;
            endcase
          end
          StWrite, StRead: begin
            unique case (phase)
              2'd1: scl_oe <= 1'b0;
              2'd2: begin
                rx_bit <= sda_i;
                if (state == StRead && slot != 4'd8) rdata <= {rdata[6:0], sda_i};
              end
              2'd3: begin
                // SCL is pulled low at the end of every slot, including the last one.
                scl_oe <= 1'b1;
                if (slot == 4'd8) begin
                  sda_oe <= 1'b0;
                  if (state == StWrite) ack_err <= rx_bit;
                end else begin
                  slot <= slot + 4'd1;
                  txd  <= {txd[6:0], 1'b0};
                  if (state == StWrite) sda_oe <= (slot == 4'd7) ? 1'b0 : ~txd[6];
                  else                  sda_oe <= (slot == 4'd7) ? ack_bit : 1'b0;
                end
              end
              default: ;
            endcase
          end
          StStop: begin
            unique case (phase)
              2'd0:    scl_oe <= 1'b0;
              2'd1:    sda_oe <= 1'b0;
              default: ;
            endcase
          end
          default: ;
        endcase
        if (last) begin
          state     <= StIdle;
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_mst.sv
// Bench for i2c_mst: open-drain bus with pull-ups, a small slave model and a
// cycle-level reference of the master's line and handshake behaviour.
module tb_i2c_mst;

  localparam int D        = 4;
  localparam int ModeNone = 0;
  localparam int ModeAck  = 1;
  localparam int ModeRead = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] wdata = 8'h00;
  logic       cmd_ack = 1'b0;
  logic       cmd_ready, done, ack_err, busy, scl_oe, sda_oe;
  logic [7:0] rdata;

  logic slave_sda = 1'b0;
  logic slave_scl_hold = 1'b0;
  wire  scl_line = ~(scl_oe | slave_scl_hold);
  wire  sda_line = ~(sda_oe | slave_sda);

  i2c_mst #(.CLK_DIV(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .wdata     (wdata),
    .cmd_ack   (cmd_ack),
    .done      (done),
    .rdata     (rdata),
    .ack_err   (ack_err),
    .busy      (busy),
    .scl_i     (scl_line),
    .sda_i     (sda_line),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave on the bus, sampled every clk: START/STOP detection, byte capture,
  // ACK in ModeAck, byte transmit in ModeRead until the master NACKs.
  int         mode = ModeNone;
  logic [7:0] rbyte = 8'h00;
  logic       scl_p = 1'b1, sda_p = 1'b1, rd_active = 1'b0, ninth = 1'b1;
  logic [7:0] shreg = 8'h00, got = 8'h00;
  int         bit_cnt = 0, starts = 0, stops = 0, rises = 0;

  always @(posedge clk) begin
    scl_p <= scl_line;
    sda_p <= sda_line;
    if (scl_p && scl_line && sda_p && !sda_line) begin
      starts    <= starts + 1;
      bit_cnt   <= 0;
      rd_active <= (mode == ModeRead);
    end else if (scl_p && scl_line && !sda_p && sda_line) begin
      stops <= stops + 1;
    end else if (!scl_p && scl_line) begin
      rises <= rises + 1;
      if (bit_cnt == 8) begin
        ninth   <= sda_line;
        bit_cnt <= 0;
        if (sda_line) rd_active <= 1'b0;
      end else begin
        shreg   <= {shreg[6:0], sda_line};
        bit_cnt <= bit_cnt + 1;
        if (bit_cnt == 7) got <= {shreg[6:0], sda_line};
      end
    end else if (scl_p && !scl_line) begin
      slave_sda <= (mode == ModeAck && bit_cnt == 8) ||
                   (rd_active && bit_cnt < 8 && ((rbyte << bit_cnt) & 8'h80) == 8'h00);
    end
  end

  // Expected {scl_oe, sda_oe} of a command, e unstretched cycles after acceptance.
  function automatic logic [1:0] exp_lines(input int c, input logic [7:0] d, input logic a,
                                           input logic ps, input int e);
    int         ph, sl;
    logic       s, q;
    logic [7:0] t;
    ph = (e / D) % 4;
    sl = e / (4 * D);
    t  = d << sl;
    case (c)
      0:       begin s = (ph == 0) ? ps : (ph == 3); q = (ph >= 2); end
      1:       begin s = (ph < 2); q = (sl < 8) ? ~t[7] : 1'b0; end
      2:       begin s = (ph < 2); q = (sl < 8) ? 1'b0 : a; end
      default: begin s = (ph == 0); q = (ph < 2); end
    endcase
    return {s, q};
  endfunction

  initial begin : model
    int         c, eff, len;
    logic [7:0] d, mrd;
    logic       a, ps, act, mdone, mscl, msda, mack, es, eq;
    logic [1:0] el;
    c = 0; eff = 0; len = 0; d = 8'h00; mrd = 8'h00;
    a = 1'b0; ps = 1'b0; act = 1'b0; mdone = 1'b0; mscl = 1'b0; msda = 1'b0; mack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 1'b0; mdone = 1'b0; mscl = 1'b0; msda = 1'b0; mrd = 8'h00; mack = 1'b0;
        chk("rst_scl_oe", 32'(scl_oe), 32'd0);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);
      end else begin
        if (act) begin
          el = exp_lines(c, d, a, ps, eff);
          es = el[1];
          eq = el[0];
        end else begin
          es = mscl;
          eq = msda;
        end
        chk("scl_oe", 32'(scl_oe), 32'(es));
        chk("sda_oe", 32'(sda_oe), 32'(eq));
        chk("busy", 32'(busy), 32'(act));
        chk("cmd_ready", 32'(cmd_ready), 32'(!act));
        chk("done", 32'(done), 32'(!act && mdone));
        chk("ack_err", 32'(ack_err), 32'(mack));
        if (!(act && c == 2)) chk("rdata", 32'(rdata), 32'(mrd));
        if (act) begin
          if (!(es == 1'b0 && scl_line == 1'b0)) eff++;
          if (eff == len) begin
            act   = 1'b0;
            mdone = 1'b1;
            mscl  = (c != 3);
            msda  = (c == 0);
            if (c == 2) mrd = rbyte;
            if (c == 1) mack = (mode != ModeAck);
          end
        end else begin
          mdone = 1'b0;
          if (cmd_valid) begin
            act = 1'b1;
            c   = int'(cmd);
            d   = wdata;
            a   = cmd_ack;
            ps  = mscl;
            eff = 0;
            len = (c == 1 || c == 2) ? 36 * D : 4 * D;
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic a,
                       input logic keep, output int t);
    int n;
    n = 0;
    cmd = c; wdata = d; cmd_ack = a; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: cmd_ready stayed %0b, expected 1", cmd_ready);
    end
    @(posedge clk); #1;
    t = cyc;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int t);
    int n;
    n = 0;
    t = -1;
    while (n < 5000) begin
      @(negedge clk);
      if (done) begin
        t = cyc;
        break;
      end
      n++;
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done stayed %0b, expected 1", done);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    while (cyc < target && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin : main
    int t0, t1, ta, r0, s0, p0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_ready", 32'(cmd_ready), 32'd1);
    chk("init_scl_oe", 32'(scl_oe), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // START, WRITE 0xA5 acked, STOP
    mode = ModeAck;
    s0 = starts; p0 = stops;
    issue(2'b00, 8'h00, 1'b0, 1'b0, t0);
    wait_done(t1);
    chk("start_latency", 32'(t1 - t0), 32'd16);
    issue(2'b01, 8'hA5, 1'b0, 1'b0, t0);
    r0 = rises;
    wait_done(t1);
    chk("wr_latency", 32'(t1 - t0), 32'd144);
    chk("wr_ack_err", 32'(ack_err), 32'd0);
    chk("wr_scl_rises", 32'(rises - r0), 32'd9);
    chk("wr_byte", 32'(got), 32'hA5);
    issue(2'b11, 8'h00, 1'b0, 1'b0, t0);
    wait_done(t1);
    chk("stop_latency", 32'(t1 - t0), 32'd16);
    chk("start_seen", 32'(starts - s0), 32'd1);
    chk("stop_seen", 32'(stops - p0), 32'd1);

    // WRITE 0x3C, nobody acks
    mode = ModeNone;
    issue(2'b00, 8'h00, 1'b0, 1'b0, t0);
    wait_done(t1);
    issue(2'b01, 8'h3C, 1'b0, 1'b0, t0);
    wait_done(t1);
    chk("nack_ack_err", 32'(ack_err), 32'd1);
    chk("nack_byte", 32'(got), 32'h3C);
    issue(2'b11, 8'h00, 1'b0, 1'b0, t0);
    wait_done(t1);

    // Reset in the middle of a WRITE
    issue(2'b01, 8'h81, 1'b0, 1'b0, t0);
    repeat (30) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_scl_oe", 32'(scl_oe), 32'd0);
    chk("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack_err", 32'(ack_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // READ 0x5A with ACK then with NACK
    mode = ModeRead; rbyte = 8'h5A;
    p0 = stops;
    issue(2'b00, 8'h00, 1'b0, 1'b0, t0);
    wait_done(t1);
    issue(2'b10, 8'h00, 1'b1, 1'b0, t0);
    wait_done(t1);
    chk("rd_latency", 32'(t1 - t0), 32'd144);
    chk("rd_ack_rdata", 32'(rdata), 32'h5A);
    chk("rd_ack_ninth", 32'(ninth), 32'd0);
    issue(2'b10, 8'h00, 1'b0, 1'b0, t0);
    wait_done(t1);
    chk("rd_nack_rdata", 32'(rdata), 32'h5A);
    chk("rd_nack_ninth", 32'(ninth), 32'd1);
    issue(2'b11, 8'h00, 1'b0, 1'b0, t0);
    wait_done(t1);
    chk("rd_stop_seen", 32'(stops - p0), 32'd1);

    // Slave stretches SCL for 50 cycles in bit 3 of a WRITE
    mode = ModeAck;
    issue(2'b00, 8'h00, 1'b0, 1'b0, t0);
    wait_done(t1);
    issue(2'b01, 8'h96, 1'b0, 1'b0, t0);
    wait_cyc(t0 + 55);
    slave_scl_hold = 1'b1;
    wait_cyc(t0 + 106);
    slave_scl_hold = 1'b0;
    wait_done(t1);
    chk("stretch_latency", 32'(t1 - t0), 32'd194);
    chk("stretch_byte", 32'(got), 32'h96);
    chk("stretch_ack_err", 32'(ack_err), 32'd0);
    issue(2'b11, 8'h00, 1'b0, 1'b0, t0);
    wait_done(t1);

    // START, WRITE with cmd_valid held through busy, repeated START, READ, STOP
    s0 = starts; p0 = stops;
    issue(2'b00, 8'h00, 1'b0, 1'b1, ta);
    issue(2'b01, 8'h42, 1'b0, 1'b0, t0);
    chk("held_valid_accept", 32'(t0 - ta), 32'd17);
    wait_done(t1);
    chk("rs_wr_byte", 32'(got), 32'h42);
    mode = ModeRead; rbyte = 8'hC3;
    issue(2'b00, 8'h00, 1'b0, 1'b0, t0);
    wait_done(t1);
    issue(2'b10, 8'h00, 1'b0, 1'b0, t0);
    wait_done(t1);
    chk("rs_rdata", 32'(rdata), 32'hC3);
    issue(2'b11, 8'h00, 1'b0, 1'b0, t0);
    wait_done(t1);
    chk("rs_starts", 32'(starts - s0), 32'd2);
    chk("rs_stops", 32'(stops - p0), 32'd1);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
